// File: rtl/demux_1x2_stream_pkg.sv
// rtl/demux_1x2_stream_pkg.sv - shared occupancy encodings for the 1x2 stream demux
package demux_1x2_stream_pkg;

    // Occupancy of a 2-entry output buffer; the encoding doubles as the word count.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

endpackage

// File: rtl/fifo2_stream.sv
// rtl/fifo2_stream.sv - 2-entry FIFO with push/pop/full/empty/head
module fifo2_stream
    import demux_1x2_stream_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    occ_t             occ;
    occ_t             occ_next;
    logic [WIDTH-1:0] mem0;
    logic [WIDTH-1:0] mem1;
    logic             do_push;
    logic             do_pop;

    // A push into a full buffer or a pop from an empty one is ignored.
    assign do_push = push && (occ != OCC_FULL);
    assign do_pop  = pop && (occ != OCC_EMPTY);

    // Occupancy state register; reset discards any buffered words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ <= OCC_EMPTY;
        end else begin
            occ <= occ_next;
        end
    end

    // Occupancy transitions; push+pop at ONE keeps the count unchanged.
    always_comb begin
        occ_next = occ;
        case (occ)
            OCC_EMPTY: begin
                if (do_push) begin
                    occ_next = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (do_push && !do_pop) begin
                    occ_next = OCC_FULL;
                end else if (do_pop && !do_push) begin
                    occ_next = OCC_EMPTY;
                end
            end
            OCC_FULL: begin
                if (do_pop) begin
                    occ_next = OCC_ONE;
                end
            end
            default: occ_next = OCC_EMPTY;
        endcase
    end

    // Storage: mem0 is always the head; a pop shifts mem1 forward.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem0 <= '0;
            mem1 <= '0;
        end else if (do_push && do_pop) begin
            // Only reachable at ONE: the new word replaces the departing head.
            mem0 <= push_data;
        end else if (do_push) begin
            if (occ == OCC_EMPTY) begin
                mem0 <= push_data;
            end else begin
                mem1 <= push_data;
            end
        end else if (do_pop) begin
            mem0 <= mem1;
        end
    end

    assign full  = (occ == OCC_FULL);
    assign empty = (occ == OCC_EMPTY);
    assign head  = mem0;

endmodule

// File: rtl/demux_1x2_stream.sv
// rtl/demux_1x2_stream.sv - registered flow-controlled 1x2 demux with per-output counters
module demux_1x2_stream
    import demux_1x2_stream_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     in0,
    input  logic                 in_valid,
    input  logic                 sel,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     out0,
    output logic                 out0_valid,
    input  logic                 out0_ready,
    output logic [WIDTH-1:0]     out1,
    output logic                 out1_valid,
    input  logic                 out1_ready,
    input  logic                 cnt_clr,
    output logic [CNT_WIDTH-1:0] cnt0,
    output logic [CNT_WIDTH-1:0] cnt1
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic             full0;
    logic             full1;
    logic             empty0;
    logic             empty1;
    logic [WIDTH-1:0] head0;
    logic [WIDTH-1:0] head1;
    logic             accept;
    logic             push0;
    logic             push1;
    logic             pop0;
    logic             pop1;

    // Ready depends only on the selected buffer's registered fullness, so a
    // full target stalls the input even if the other buffer has room.
    assign in_ready = !rst && (sel ? !full1 : !full0);
    assign accept   = in_valid && in_ready;
    assign push0    = accept && !sel;
    assign push1    = accept && sel;

    assign out0_valid = !empty0;
    assign out1_valid = !empty1;
    assign out0       = out0_valid ? head0 : '0;
    assign out1       = out1_valid ? head1 : '0;
    assign pop0       = out0_valid && out0_ready;
    assign pop1       = out1_valid && out1_ready;

    fifo2_stream #(.WIDTH(WIDTH)) u_fifo0 (
        .clk       (clk),
        .rst       (rst),
        .push      (push0),
        .push_data (in0),
        .pop       (pop0),
        .full      (full0),
        .empty     (empty0),
        .head      (head0)
    );

    fifo2_stream #(.WIDTH(WIDTH)) u_fifo1 (
        .clk       (clk),
        .rst       (rst),
        .push      (push1),
        .push_data (in0),
        .pop       (pop1),
        .full      (full1),
        .empty     (empty1),
        .head      (head1)
    );

    // Saturating delivery counters; clear wins over a same-cycle pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else if (cnt_clr) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (pop0 && (cnt0 != CNT_MAX)) begin
                cnt0 <= cnt0 + 1'b1;
            end
            if (pop1 && (cnt1 != CNT_MAX)) begin
                cnt1 <= cnt1 + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_demux_1x2_stream.sv
// tb/tb_demux_1x2_stream.sv - randomized self-checking bench for demux_1x2_stream
module tb_demux_1x2_stream;

    logic       clk;
    logic       rst;
    logic [3:0] in0;
    logic       in_valid;
    logic       sel;
    logic       in_ready;
    logic [3:0] out0;
    logic       out0_valid;
    logic       out0_ready;
    logic [3:0] out1;
    logic       out1_valid;
    logic       out1_ready;
    logic       cnt_clr;
    logic [7:0] cnt0;
    logic [7:0] cnt1;

    logic       s_in_ready;
    logic [3:0] s_out0;
    logic       s_out0_valid;
    logic [3:0] s_out1;
    logic       s_out1_valid;
    logic [3:0] s_cnt0;
    logic [3:0] s_cnt1;

    int n_checks = 0;
    int n_err    = 0;

    logic [3:0] q0[$];
    logic [3:0] q1[$];
    int m_cnt0, m_cnt1, m_sat0, m_sat1;

    demux_1x2_stream dut (
        .clk(clk), .rst(rst), .in0(in0), .in_valid(in_valid), .sel(sel),
        .in_ready(in_ready), .out0(out0), .out0_valid(out0_valid), .out0_ready(out0_ready),
        .out1(out1), .out1_valid(out1_valid), .out1_ready(out1_ready),
        .cnt_clr(cnt_clr), .cnt0(cnt0), .cnt1(cnt1)
    );

    demux_1x2_stream #(.WIDTH(4), .CNT_WIDTH(4)) dut_sat (
        .clk(clk), .rst(rst), .in0(in0), .in_valid(in_valid), .sel(sel),
        .in_ready(s_in_ready), .out0(s_out0), .out0_valid(s_out0_valid), .out0_ready(out0_ready),
        .out1(s_out1), .out1_valid(s_out1_valid), .out1_ready(out1_ready),
        .cnt_clr(cnt_clr), .cnt0(s_cnt0), .cnt1(s_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        q0.delete();
        q1.delete();
        m_cnt0 = 0;
        m_cnt1 = 0;
        m_sat0 = 0;
        m_sat1 = 0;
    endtask

    // Compare every observable output against the queue model.
    task automatic compare_all();
        bit exp_ready;
        exp_ready = !rst && (sel ? (q1.size() < 2) : (q0.size() < 2));
        check_eq("in_ready", 32'(in_ready), 32'(exp_ready));
        check_eq("out0_valid", 32'(out0_valid), 32'(q0.size() != 0));
        check_eq("out1_valid", 32'(out1_valid), 32'(q1.size() != 0));
        check_eq("out0", 32'(out0), (q0.size() != 0) ? 32'(q0[0]) : 32'd0);
        check_eq("out1", 32'(out1), (q1.size() != 0) ? 32'(q1[0]) : 32'd0);
        check_eq("cnt0", 32'(cnt0), 32'(m_cnt0));
        check_eq("cnt1", 32'(cnt1), 32'(m_cnt1));
        check_eq("sat_in_ready", 32'(s_in_ready), 32'(exp_ready));
        check_eq("sat_cnt0", 32'(s_cnt0), 32'(m_sat0));
        check_eq("sat_cnt1", 32'(s_cnt1), 32'(m_sat1));
    endtask

    // One clock: drive inputs after the falling edge, check, then advance the model at the rising edge.
    task automatic step(input bit v, input bit s, input logic [3:0] d, input bit r0, input bit r1,
                        input bit clr, output bit acc);
        bit p0, p1;
        @(negedge clk);
        in_valid   = v;
        sel        = s;
        in0        = d;
        out0_ready = r0;
        out1_ready = r1;
        cnt_clr    = clr;
        #1;
        compare_all();
        acc = v && !rst && (s ? (q1.size() < 2) : (q0.size() < 2));
        p0  = (q0.size() != 0) && r0;
        p1  = (q1.size() != 0) && r1;
        @(posedge clk);
        if (p0) void'(q0.pop_front());
        if (p1) void'(q1.pop_front());
        if (acc) begin
            if (s) q1.push_back(d);
            else   q0.push_back(d);
        end
        if (clr) begin
            m_cnt0 = 0; m_cnt1 = 0; m_sat0 = 0; m_sat1 = 0;
        end else begin
            if (p0) begin
                if (m_cnt0 < 255) m_cnt0++;
                if (m_sat0 < 15)  m_sat0++;
            end
            if (p1) begin
                if (m_cnt1 < 255) m_cnt1++;
                if (m_sat1 < 15)  m_sat1++;
            end
        end
    endtask

    initial begin
        bit a;
        bit pend_v;
        bit pend_s;
        logic [3:0] pend_d;
        int tries;

        rst = 1'b1; in0 = 4'h7; in_valid = 1'b1; sel = 1'b0;
        out0_ready = 1'b1; out1_ready = 1'b1; cnt_clr = 1'b0;
        model_clear();
        #12;
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_out0_valid", 32'(out0_valid), 32'd0);
        check_eq("rst_out0", 32'(out0), 32'd0);
        check_eq("rst_cnt0", 32'(cnt0), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;

        // Zero-masking with input activity but nothing accepted.
        for (int i = 0; i < 4; i++) step(1'b0, 1'($urandom), 4'($urandom), 1'b1, 1'b1, 1'b0, a);

        // Routing.
        step(1'b1, 1'b0, 4'h3, 1'b1, 1'b1, 1'b0, a);
        #1;
        check_eq("route_out0", 32'(out0), 32'h3);
        step(1'b1, 1'b1, 4'hA, 1'b1, 1'b1, 1'b0, a);
        #1;
        check_eq("route_out1", 32'(out1), 32'hA);
        step(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, a);
        #1;
        check_eq("route_cnt0", 32'(cnt0), 32'd1);
        check_eq("route_cnt1", 32'(cnt1), 32'd1);

        // Backpressure on output 0 with a side word to output 1.
        step(1'b1, 1'b0, 4'h1, 1'b0, 1'b1, 1'b0, a);
        check_eq("bp_acc1", 32'(a), 32'd1);
        step(1'b1, 1'b0, 4'h2, 1'b0, 1'b1, 1'b0, a);
        check_eq("bp_acc2", 32'(a), 32'd1);
        step(1'b1, 1'b0, 4'h3, 1'b0, 1'b1, 1'b0, a);
        check_eq("bp_stall", 32'(in_ready), 32'd0);
        step(1'b1, 1'b1, 4'h9, 1'b0, 1'b0, 1'b0, a);
        check_eq("bp_side_acc", 32'(a), 32'd1);
        #1;
        check_eq("bp_side_out1", 32'(out1), 32'h9);
        tries = 0;
        a = 1'b0;
        while (!a && tries < 8) begin
            step(1'b1, 1'b0, 4'h3, 1'b1, 1'b1, 1'b0, a);
            tries++;
        end
        check_eq("bp_resume", 32'(a), 32'd1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, a);

        // Continuous stream at occupancy ONE.
        step(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, a);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 4'($urandom), 1'b1, 1'b1, 1'b0, a);
            check_eq("stream_acc", 32'(a), 32'd1);
        end
        step(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, a);
        step(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, a);
        #1;
        check_eq("stream_cnt0", 32'(cnt0), 32'd16);

        // Saturation on the 4-bit counters, then clear during a pop.
        step(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, a);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 4'($urandom), 1'b1, 1'b1, 1'b0, a);
        step(1'b0, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0, a);
        step(1'b0, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0, a);
        #1;
        check_eq("sat_cnt1_15", 32'(s_cnt1), 32'd15);
        check_eq("wide_cnt1_20", 32'(cnt1), 32'd20);
        step(1'b1, 1'b1, 4'h5, 1'b1, 1'b1, 1'b0, a);
        step(1'b0, 1'b1, 4'h0, 1'b1, 1'b1, 1'b1, a);
        #1;
        check_eq("clr_cnt1", 32'(s_cnt1), 32'd0);
        check_eq("clr_wide_cnt1", 32'(cnt1), 32'd0);

        // Randomized traffic; a stalled word is held, though SEL may move.
        pend_v = 1'b0; pend_s = 1'b0; pend_d = 4'h0;
        for (int i = 0; i < 400; i++) begin
            if (!pend_v && ($urandom_range(3) != 0)) begin
                pend_v = 1'b1;
                pend_s = 1'($urandom);
                pend_d = 4'($urandom);
            end else if (pend_v && ($urandom_range(7) == 0)) begin
                pend_s = 1'($urandom);
            end
            step(pend_v, pend_s, pend_d, ($urandom_range(3) != 0), ($urandom_range(2) != 0),
                 ($urandom_range(31) == 0), a);
            if (a) pend_v = 1'b0;
        end

        // Reset mid-stream with buffer 0 full.
        step(1'b1, 1'b0, 4'hC, 1'b0, 1'b1, 1'b0, a);
        step(1'b1, 1'b0, 4'hD, 1'b0, 1'b1, 1'b0, a);
        step(1'b1, 1'b0, 4'hE, 1'b0, 1'b1, 1'b0, a);
        check_eq("pre_rst_full", 32'(in_ready), 32'd0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("mid_rst_out0_valid", 32'(out0_valid), 32'd0);
        check_eq("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("mid_rst_cnt0", 32'(cnt0), 32'd0);
        check_eq("mid_rst_out0", 32'(out0), 32'd0);
        model_clear();
        @(posedge clk);
        #2;
        rst = 1'b0;
        step(1'b1, 1'b0, 4'h5, 1'b0, 1'b1, 1'b0, a);
        check_eq("post_rst_acc", 32'(a), 32'd1);
        #1;
        check_eq("post_rst_out0", 32'(out0), 32'h5);
        step(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, a);
        step(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, a);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
